// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using the shift-and-add-3 (double
//   dabble) algorithm, one input bit per clock. Turns a binary value into
//   DIGITS BCD digits for the display path. It flags values that do not fit in
//   DIGITS decimal digits and produces a leading-zero blanking mask.
//
// Parameters
//   IN_W        width of the binary input (>= 4)
//   DIGITS      number of BCD output digits (>= 1)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       conversion request, sampled only while busy = 0
//   bin_in      binary value, captured on the accepting edge
//   busy        conversion in progress, including the done cycle
//   done        one-cycle pulse: bcd_out / ovf / blank_mask just updated
//   bcd_out     result, digit k at [4k+3:4k], k = 0 least significant
//   ovf         bin_in >= 10**DIGITS (held until the next done)
//   blank_mask  bit k = 1: digit k is a leading zero (bit 0 always 0)
//
// Timing
//   start accepted at edge T, IN_W shift iterations on edges T+1..T+IN_W,
//   outputs registered on edge T+IN_W+1 with done high for the following
//   cycle. busy stays high through that done cycle, so a start seen during
//   the done cycle is ignored. The next start is taken in the cycle after it.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add 3 to every digit that is 5 or more. Digits are handled independently:
  // no carry ever crosses a digit boundary.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return res;
  endfunction

  // Leading-zero mask: bit k is set when digit k and every higher digit are
  // zero. Digit 0 is always shown, so a value of zero still displays "0".
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] m;
    logic              upper_zero;
    m          = {DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (bcd[4*k +: 4] == 4'd0);
      m[k]       = upper_zero;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  // The mask for an all-zero result is also the reset value of blank_mask.
  localparam logic [DIGITS-1:0] BLANK_RST = blank_of({BCD_W{1'b0}});

  state_t                state_r;
  logic [IN_W-1:0]       shift_reg_r;
  logic [BCD_W-1:0]      bcd_scr_r;
  logic                  ovf_scr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [BCD_W-1:0]      bcd_out_r;
  logic                  ovf_r;
  logic [DIGITS-1:0]     blank_r;

  logic [BCD_W-1:0]      adj_s;
  logic [BCD_W:0]        step_s;

  // One double-dabble iteration. After the add-3 correction, the scratch
  // digits and the shift register are shifted left as one vector. The MSB of
  // the binary shift register enters BCD bit 0. step_s[BCD_W] is the bit
  // that leaves the top digit: if it is ever 1, the value has overflowed.
  always_comb begin
    adj_s  = {BCD_W{1'b0}};
    step_s = {(BCD_W + 1){1'b0}};
    adj_s  = add3_digits(bcd_scr_r);
    step_s = {adj_s, shift_reg_r[IN_W-1]};
  end

  // Control FSM, scratch datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_reg_r <= {IN_W{1'b0}};
      bcd_scr_r   <= {BCD_W{1'b0}};
      ovf_scr_r   <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bcd_out_r   <= {BCD_W{1'b0}};
      ovf_r       <= 1'b0;
      blank_r     <= BLANK_RST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          // While done_r is high (the done cycle), busy_r is still 1. That
          // keeps a start in this cycle from being accepted.
          if (start && !busy_r) begin
            shift_reg_r <= bin_in;
            bcd_scr_r   <= {BCD_W{1'b0}};
            ovf_scr_r   <= 1'b0;
            cnt_r       <= CNT_W'(IN_W);
            busy_r      <= 1'b1;
            state_r     <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          bcd_scr_r   <= step_s[BCD_W-1:0];
          ovf_scr_r   <= ovf_scr_r | step_s[BCD_W];
          shift_reg_r <= {shift_reg_r[IN_W-2:0], 1'b0};
          cnt_r       <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
          // An overflowed result saturates to all nines with no blanking.
          if (ovf_scr_r) begin
            bcd_out_r <= {DIGITS{4'd9}};
            ovf_r     <= 1'b1;
            blank_r   <= {DIGITS{1'b0}};
          end else begin
            bcd_out_r <= bcd_scr_r;
            ovf_r     <= 1'b0;
            blank_r   <= blank_of(bcd_scr_r);
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign bcd_out    = bcd_out_r;
  assign ovf        = ovf_r;
  assign blank_mask = blank_r;

endmodule
